// File: rtl/dac_sweep_sequencer.sv
// DAC threshold sweep sequencer: per DAC point it loads slow control, settles,
// emits a tagged header, runs a counted acquisition, drains late beats, then steps.
module dac_sweep_sequencer #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int DRAIN_CYCLES  = 64
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        SweepStart,
  input  logic [9:0]  StartDac,
  input  logic [9:0]  EndDac,
  input  logic [9:0]  DacStep,
  input  logic [15:0] MaxPackageNumber,
  input  logic        MicrorocConfigDone,
  input  logic [15:0] ParallelData,
  input  logic        ParallelData_en,
  input  logic        UsbDataFifoFull,
  input  logic        DataTransmitDone,
  output logic [9:0]  OutDac,
  output logic        LoadSCParameters,
  output logic        AcqStartStop,
  output logic [15:0] SweepAcqData,
  output logic        SweepAcqData_en,
  output logic        SweepTestDone
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT_CFG, S_SETTLE, S_HEADER,
    S_ACQ, S_STOP, S_NEXT, S_WAIT_TX, S_DONE
  } state_t;

  localparam int          CNT_MAX  = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
  localparam int          CNT_W    = $clog2(CNT_MAX + 2);
  localparam logic [31:0] SETTLE_U = 32'(SETTLE_CYCLES);
  localparam logic [31:0] DRAIN_U  = 32'(DRAIN_CYCLES);

  state_t             state_q, state_d;
  logic               start_q;
  logic [9:0]         out_dac_q, out_dac_d;
  logic [9:0]         end_dac_q, end_dac_d;
  logic [9:0]         step_q, step_d;
  logic [15:0]        max_q, max_d;
  logic [15:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic               load_q, load_d;
  logic               acq_q, acq_d;
  logic [15:0]        data_q, data_d;
  logic               data_en_q, data_en_d;
  logic               done_q, done_d;

  logic               start_edge_s;
  logic               abort_s;
  logic [9:0]         step_eff_s;
  logic [10:0]        sum_s;
  logic               cyc_last_settle_s;
  logic               cyc_last_drain_s;

  assign start_edge_s      = SweepStart & ~start_q;
  assign abort_s           = ~SweepStart && (state_q != S_IDLE) && (state_q != S_DONE);
  assign step_eff_s        = (step_q == 10'd0) ? 10'd1 : step_q;
  assign sum_s             = {1'b0, out_dac_q} + {1'b0, step_eff_s};
  assign cyc_last_settle_s = (32'(cyc_cnt_q) + 32'd1) >= SETTLE_U;
  assign cyc_last_drain_s  = (32'(cyc_cnt_q) + 32'd1) >= DRAIN_U;

  // Next-state, parameter latching, counters and output staging.
  always_comb begin
    state_d    = state_q;
    out_dac_d  = out_dac_q;
    end_dac_d  = end_dac_q;
    step_d     = step_q;
    max_d      = max_q;
    beat_cnt_d = beat_cnt_q;
    cyc_cnt_d  = '0;
    data_d     = data_q;
    data_en_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge_s) begin
          out_dac_d = StartDac;
          end_dac_d = EndDac;
          step_d    = DacStep;
          max_d     = MaxPackageNumber;
          state_d   = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        beat_cnt_d = 16'd0;
        state_d    = S_WAIT_CFG;
      end
      S_WAIT_CFG: begin
        if (MicrorocConfigDone) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_WAIT_CFG;
        end
      end
      S_SETTLE: begin
        if (cyc_last_settle_s) begin
          state_d = S_HEADER;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
      end
      S_HEADER: begin
        if (!UsbDataFifoFull) begin
          data_d    = {6'b101010, out_dac_q};
          data_en_d = 1'b1;
          state_d   = (max_q == 16'd0) ? S_NEXT : S_ACQ;
        end else begin
          state_d = S_HEADER;
        end
      end
      S_ACQ: begin
        if (ParallelData_en) begin
          data_d     = ParallelData;
          data_en_d  = 1'b1;
          beat_cnt_d = beat_cnt_q + 16'd1;
          if ((beat_cnt_q + 16'd1) == max_q) begin
            state_d = S_STOP;
          end else begin
            state_d = S_ACQ;
          end
        end else begin
          state_d = S_ACQ;
        end
      end
      S_STOP: begin
        // Late beats still reach the stream but no longer count toward the point.
        if (ParallelData_en) begin
          data_d    = ParallelData;
          data_en_d = 1'b1;
        end else begin
          data_en_d = 1'b0;
        end
        if (cyc_last_drain_s) begin
          state_d = S_NEXT;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (sum_s[10] || (sum_s[9:0] > end_dac_q)) begin
          state_d = S_WAIT_TX;
        end else begin
          out_dac_d = sum_s[9:0];
          state_d   = S_LOAD;
        end
      end
      S_WAIT_TX: begin
        if (DataTransmitDone) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_TX;
        end
      end
      S_DONE: begin
        if (!SweepStart) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_s) begin
      state_d   = S_IDLE;
      data_en_d = 1'b0;
      cyc_cnt_d = '0;
    end else begin
      cyc_cnt_d = cyc_cnt_d;
    end
  end

  assign load_d = (state_q == S_LOAD) && !abort_s;
  assign acq_d  = (state_d == S_ACQ);
  assign done_d = (state_d == S_DONE);

  // State, parameter and registered-output update with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      out_dac_q  <= 10'd0;
      end_dac_q  <= 10'd0;
      step_q     <= 10'd0;
      max_q      <= 16'd0;
      beat_cnt_q <= 16'd0;
      cyc_cnt_q  <= '0;
      load_q     <= 1'b0;
      acq_q      <= 1'b0;
      data_q     <= 16'd0;
      data_en_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= SweepStart;
      out_dac_q  <= out_dac_d;
      end_dac_q  <= end_dac_d;
      step_q     <= step_d;
      max_q      <= max_d;
      beat_cnt_q <= beat_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      load_q     <= load_d;
      acq_q      <= acq_d;
      data_q     <= data_d;
      data_en_q  <= data_en_d;
      done_q     <= done_d;
    end
  end

  assign OutDac           = out_dac_q;
  assign LoadSCParameters = load_q;
  assign AcqStartStop     = acq_q;
  assign SweepAcqData     = data_q;
  assign SweepAcqData_en  = data_en_q;
  assign SweepTestDone    = done_q;

endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Self-checking bench for dac_sweep_sequencer: scoreboard on the tagged stream
// plus per-scenario tasks checking control timing.
module tb_dac_sweep_sequencer;

  localparam int SETTLE = 8;
  localparam int DRAIN  = 4;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SweepStart = 1'b0;
  logic [9:0]  StartDac = 10'd0;
  logic [9:0]  EndDac = 10'd0;
  logic [9:0]  DacStep = 10'd0;
  logic [15:0] MaxPackageNumber = 16'd0;
  logic        MicrorocConfigDone = 1'b0;
  logic [15:0] ParallelData = 16'd0;
  logic        ParallelData_en = 1'b0;
  logic        UsbDataFifoFull = 1'b0;
  logic        DataTransmitDone = 1'b0;
  logic [9:0]  OutDac;
  logic        LoadSCParameters;
  logic        AcqStartStop;
  logic [15:0] SweepAcqData;
  logic        SweepAcqData_en;
  logic        SweepTestDone;

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;
  int acq_cnt  = 0;
  int words    = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  dac_sweep_sequencer #(.SETTLE_CYCLES(SETTLE), .DRAIN_CYCLES(DRAIN)) dut (
    .Clk(Clk), .reset_n(reset_n), .SweepStart(SweepStart),
    .StartDac(StartDac), .EndDac(EndDac), .DacStep(DacStep),
    .MaxPackageNumber(MaxPackageNumber), .MicrorocConfigDone(MicrorocConfigDone),
    .ParallelData(ParallelData), .ParallelData_en(ParallelData_en),
    .UsbDataFifoFull(UsbDataFifoFull), .DataTransmitDone(DataTransmitDone),
    .OutDac(OutDac), .LoadSCParameters(LoadSCParameters), .AcqStartStop(AcqStartStop),
    .SweepAcqData(SweepAcqData), .SweepAcqData_en(SweepAcqData_en),
    .SweepTestDone(SweepTestDone)
  );

  always #5 Clk = ~Clk;

  // Stream scoreboard and control-pulse counters, sampled on the falling edge.
  always @(negedge Clk) begin
    if (LoadSCParameters) load_cnt++;
    if (AcqStartStop) acq_cnt++;
    if (SweepAcqData_en) begin
      words++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_unexpected got=%h expected=<none>", SweepAcqData);
      end else begin
        exp_w = exp_q.pop_front();
        if (SweepAcqData !== exp_w) begin
          n_fail++;
          $display("FAIL stream_word got=%h expected=%h", SweepAcqData, exp_w);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (LoadSCParameters) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic start_sweep(input logic [9:0] s, input logic [9:0] e,
                             input logic [9:0] st, input logic [15:0] m);
    SweepStart = 1'b0;
    StartDac = s; EndDac = e; DacStep = st; MaxPackageNumber = m;
    tick(); tick();
    load_cnt = 0;
    SweepStart = 1'b1;
  endtask

  task automatic do_point(input logic [9:0] dac, input logic [15:0] maxp, input int beats,
                          input int full_hold, input bit drain_beat);
    bit ok;
    int k;
    logic [15:0] w;
    wait_load(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL load_timeout got=none expected=pulse dac=%0d", dac);
      return;
    end
    n_checks++;
    if (OutDac !== dac) begin
      n_fail++;
      $display("FAIL out_dac got=%0d expected=%0d", OutDac, dac);
    end
    exp_q.push_back({6'b101010, dac});
    if (full_hold > 0) UsbDataFifoFull = 1'b1;
    tick(); MicrorocConfigDone = 1'b1;
    tick(); MicrorocConfigDone = 1'b0;
    if (full_hold > 0) begin
      k = 0;
      repeat (SETTLE + full_hold) begin
        @(negedge Clk);
        if (SweepAcqData_en) k++;
      end
      tick(); UsbDataFifoFull = 1'b0;
      @(negedge Clk);
      n_checks++;
      if (SweepAcqData_en !== 1'b0 || k != 0) begin
        n_fail++;
        $display("FAIL header_while_full got=%0d strobes expected=0", k + int'(SweepAcqData_en));
      end
      @(negedge Clk);
      n_checks++;
      if (SweepAcqData_en !== 1'b1) begin
        n_fail++;
        $display("FAIL header_after_full got=%b expected=1", SweepAcqData_en);
      end
    end else begin
      k = 0;
      while (k < SETTLE + 40) begin
        @(negedge Clk);
        if (SweepAcqData_en) break;
        k++;
      end
      n_checks++;
      if (k != SETTLE + 1) begin
        n_fail++;
        $display("FAIL header_latency got=%0d expected=%0d", k, SETTLE + 1);
      end
    end
    n_checks++;
    if (AcqStartStop !== (maxp != 16'd0)) begin
      n_fail++;
      $display("FAIL acq_after_header got=%b expected=%b", AcqStartStop, (maxp != 16'd0));
    end
    for (int i = 0; i < beats; i++) begin
      tick();
      w = 16'($urandom);
      ParallelData = w; ParallelData_en = 1'b1;
      exp_q.push_back(w);
      tick();
      ParallelData_en = 1'b0;
    end
    if (beats == int'(maxp) && maxp != 16'd0) begin
      @(negedge Clk);
      n_checks++;
      if (AcqStartStop !== 1'b0) begin
        n_fail++;
        $display("FAIL acq_fall got=%b expected=0", AcqStartStop);
      end
      if (drain_beat) begin
        tick();
        w = 16'($urandom);
        ParallelData = w; ParallelData_en = 1'b1;
        exp_q.push_back(w);
        tick();
        ParallelData_en = 1'b0;
      end
    end
  endtask

  task automatic finish_sweep(input int exp_loads);
    bit early;
    early = 1'b0;
    repeat (12) begin
      @(negedge Clk);
      if (SweepTestDone) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL done_before_tx got=1 expected=0");
    end
    n_checks++;
    if (load_cnt != exp_loads) begin
      n_fail++;
      $display("FAIL load_count got=%0d expected=%0d", load_cnt, exp_loads);
    end
    tick();
    ParallelData = 16'($urandom); ParallelData_en = 1'b1;
    tick(); ParallelData_en = 1'b0;
    DataTransmitDone = 1'b1;
    tick(); DataTransmitDone = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (SweepTestDone !== 1'b1) begin
      n_fail++;
      $display("FAIL done_after_tx got=%b expected=1", SweepTestDone);
    end
    tick(); SweepStart = 1'b0;
    tick();
    @(negedge Clk);
    n_checks++;
    if (SweepTestDone !== 1'b0) begin
      n_fail++;
      $display("FAIL done_release got=%b expected=0", SweepTestDone);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_leftover got=%0d words expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (OutDac !== 10'd0 || LoadSCParameters !== 1'b0 || AcqStartStop !== 1'b0 ||
        SweepAcqData !== 16'd0 || SweepAcqData_en !== 1'b0 || SweepTestDone !== 1'b0) begin
      n_fail++;
      $display("FAIL %s got=dac%0d ld%b acq%b d%h en%b done%b expected=all zero", tag,
               OutDac, LoadSCParameters, AcqStartStop, SweepAcqData, SweepAcqData_en, SweepTestDone);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick(); tick();
    @(negedge Clk);
    check_reset_outputs("reset_values");
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_start_latency();
    StartDac = 10'd7; EndDac = 10'd9; DacStep = 10'd1; MaxPackageNumber = 16'd3;
    tick();
    SweepStart = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (OutDac !== 10'd0 || LoadSCParameters !== 1'b0) begin
      n_fail++;
      $display("FAIL start_cycle_n got=dac%0d ld%b expected=dac0 ld0", OutDac, LoadSCParameters);
    end
    tick();
    @(negedge Clk);
    n_checks++;
    if (OutDac !== 10'd7 || LoadSCParameters !== 1'b0) begin
      n_fail++;
      $display("FAIL start_cycle_n1 got=dac%0d ld%b expected=dac7 ld0", OutDac, LoadSCParameters);
    end
    tick();
    @(negedge Clk);
    n_checks++;
    if (LoadSCParameters !== 1'b1) begin
      n_fail++;
      $display("FAIL start_cycle_n2 got=ld%b expected=ld1", LoadSCParameters);
    end
    tick(); SweepStart = 1'b0;
    tick(); tick();
  endtask

  task automatic test_basic();
    int w0;
    start_sweep(10'd100, 10'd103, 10'd1, 16'd5);
    w0 = words;
    for (int d = 100; d <= 103; d++) do_point(10'(d), 16'd5, 5, 0, 1'b0);
    finish_sweep(4);
    n_checks++;
    if (words - w0 != 24) begin
      n_fail++;
      $display("FAIL basic_word_count got=%0d expected=24", words - w0);
    end
  endtask

  task automatic test_overflow_and_reverse();
    start_sweep(10'd1020, 10'd1023, 10'd4, 16'd3);
    do_point(10'd1020, 16'd3, 3, 0, 1'b1);
    finish_sweep(1);
    start_sweep(10'd50, 10'd10, 10'd1, 16'd2);
    do_point(10'd50, 16'd2, 2, 0, 1'b0);
    finish_sweep(1);
  endtask

  task automatic test_max_zero();
    start_sweep(10'd0, 10'd2, 10'd0, 16'd0);
    acq_cnt = 0;
    for (int d = 0; d <= 2; d++) do_point(10'(d), 16'd0, 0, 0, 1'b0);
    finish_sweep(3);
    n_checks++;
    if (acq_cnt != 0) begin
      n_fail++;
      $display("FAIL max_zero_acq got=%0d cycles expected=0", acq_cnt);
    end
  endtask

  task automatic test_fifo_full();
    start_sweep(10'd300, 10'd300, 10'd1, 16'd2);
    do_point(10'd300, 16'd2, 2, 30, 1'b0);
    finish_sweep(1);
  endtask

  task automatic test_abort();
    start_sweep(10'd200, 10'd210, 10'd1, 16'd10);
    do_point(10'd200, 16'd10, 3, 0, 1'b0);
    SweepStart = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    n_checks++;
    if (AcqStartStop !== 1'b0 || SweepTestDone !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs got=acq%b done%b expected=acq0 done0", AcqStartStop, SweepTestDone);
    end
    repeat (20) @(negedge Clk);
    n_checks++;
    if (load_cnt != 1 || SweepTestDone !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle got=loads%0d done%b expected=loads1 done0", load_cnt, SweepTestDone);
    end
    start_sweep(10'd200, 10'd200, 10'd1, 16'd2);
    do_point(10'd200, 16'd2, 2, 0, 1'b0);
    finish_sweep(1);
  endtask

  task automatic test_reset_mid_stop();
    start_sweep(10'd5, 10'd5, 10'd1, 16'd2);
    do_point(10'd5, 16'd2, 2, 0, 1'b0);
    tick();
    reset_n = 1'b0; SweepStart = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge Clk);
    check_reset_outputs("reset_mid_stop");
    exp_q.delete();
    start_sweep(10'd9, 10'd10, 10'd1, 16'd1);
    do_point(10'd9, 16'd1, 1, 0, 1'b0);
    do_point(10'd10, 16'd1, 1, 0, 1'b0);
    finish_sweep(2);
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_basic();
    test_overflow_and_reverse();
    test_max_zero();
    test_fifo_full();
    test_abort();
    test_reset_mid_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
